// File: rtl/sweeper_pkg.sv
// Shared types and truth tables for the gate sweeper and its sibling harnesses.
// Table bit i holds the expected gate output for input vector i.
package sweeper_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] NAND2_TABLE = 4'b0111;
    localparam logic [3:0] AND2_TABLE  = 4'b1000;
    localparam logic [3:0] OR2_TABLE   = 4'b1110;
    localparam logic [3:0] XOR2_TABLE  = 4'b0110;

endpackage

// File: rtl/dwell_timer.sv
// Settle-time up-counter: cleared on load, flags the last dwell cycle (count == DWELL-1).
// Counting stops at the terminal value so the counter never wraps.
module dwell_timer #(
    parameter int DWELL = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [W-1:0] LAST = W'(DWELL - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/gate_truth_table_sweeper.sv
// Walks every input vector of a combinational gate, holds it DWELL cycles, then
// checks the gate output against EXPECTED and accumulates mismatch results.
module gate_truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int                          N_INPUTS = 2,
    parameter int                          DWELL    = 25,
    parameter logic [(1<<N_INPUTS)-1:0]    EXPECTED = NAND2_TABLE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                gateResult,
    output logic [N_INPUTS-1:0] gateInputs,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   failCount,
    output logic [N_INPUTS-1:0] firstFailVector
);

    localparam logic [N_INPUTS-1:0] LAST_VEC = '1;

    state_t                r_state;
    state_t                w_next;
    logic [N_INPUTS-1:0]   r_vector;
    logic [N_INPUTS:0]     r_fail_count;
    logic [N_INPUTS-1:0]   r_first_fail;
    logic                  w_expired;
    logic                  w_launch;
    logic                  w_check;
    logic                  w_mismatch;

    assign w_launch = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_check  = (r_state == S_CHECK);
    // Case inequality so an X/Z gate output is scored as a mismatch in simulation.
    assign w_mismatch = (gateResult !== EXPECTED[r_vector]);

    dwell_timer #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_launch || w_check),
        .i_en     (r_state == S_SETTLE),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_SETTLE;
            S_SETTLE:       if (w_expired) w_next = S_CHECK;
            S_CHECK:        w_next = (r_vector == LAST_VEC) ? S_DONE : S_SETTLE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vector     <= '0;
            r_fail_count <= '0;
            r_first_fail <= '0;
        end else if (w_launch) begin
            r_vector     <= '0;
            r_fail_count <= '0;
            r_first_fail <= '0;
        end else if (w_check) begin
            if (w_mismatch) begin
                r_fail_count <= r_fail_count + 1'b1;
                if (r_fail_count == '0) begin
                    r_first_fail <= r_vector;
                end
            end
            if (r_vector != LAST_VEC) begin
                r_vector <= r_vector + 1'b1;
            end
        end
    end

    assign busy            = (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign done            = (r_state == S_DONE);
    assign pass            = done && (r_fail_count == '0);
    assign gateInputs      = busy ? r_vector : '0;
    assign failCount       = r_fail_count;
    assign firstFailVector = r_first_fail;

endmodule
